// File: rtl/edge_window_gen.sv
// Streaming 3x3 neighbourhood generator for binary raster images (zero-padded borders).
// Define EDGE_WIN_BORDER_REPLICATE_EN to replicate the nearest in-image pixel at borders instead.
module edge_window_gen #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_pix,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [8:0] out_window,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    localparam int unsigned COL_W   = $clog2(IMG_W);
    localparam int unsigned ROW_W   = $clog2(IMG_H);
    localparam int unsigned FILL_W  = $clog2(IMG_W + 2);
    localparam int unsigned SR_LEN  = 2 * IMG_W + 2;
    localparam int unsigned TAP_MID = IMG_W;
    localparam int unsigned TAP_TOP = 2 * IMG_W;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic                ready_en_q;
    logic [SR_LEN-1:0]   sr_q;
    logic [SR_LEN:0]     sr_n;
    logic [COL_W-1:0]    in_col_q, cen_col_q;
    logic [ROW_W-1:0]    in_row_q, cen_row_q;
    logic [FILL_W-1:0]   fill_cnt_q;

    logic                out_free_c;
    logic                in_fire_c;
    logic                flush_fire_c;
    logic                shift_en_c;
    logic                shift_bit_c;
    logic                produce_c;
    logic                in_last_col_c, in_last_row_c, in_last_pix_c;
    logic                cen_last_col_c, cen_last_row_c, cen_last_c;
    logic [8:0]          win_c;
    logic [2:0]          p [3];

    // Handshake and shift control
    assign out_free_c     = ~out_valid | out_ready;
    assign in_ready       = ready_en_q & (state_q != FLUSH) & out_free_c;
    assign in_fire_c      = in_valid & in_ready;
    assign flush_fire_c   = (state_q == FLUSH) & out_free_c;
    assign shift_en_c     = in_fire_c | flush_fire_c;
    assign shift_bit_c    = (state_q == FLUSH) ? 1'b0 : in_pix;
    assign produce_c      = (in_fire_c & (state_q == RUN)) | flush_fire_c;
    assign sr_n           = {sr_q, shift_bit_c};

    assign in_last_col_c  = (in_col_q == COL_W'(IMG_W - 1));
    assign in_last_row_c  = (in_row_q == ROW_W'(IMG_H - 1));
    assign in_last_pix_c  = in_last_col_c & in_last_row_c;
    assign cen_last_col_c = (cen_col_q == COL_W'(IMG_W - 1));
    assign cen_last_row_c = (cen_row_q == ROW_W'(IMG_H - 1));
    assign cen_last_c     = cen_last_col_c & cen_last_row_c;

    // Neighbourhood taps p[row][col] around the centre k-(IMG_W+1), then border fix-up
    always_comb begin
        p[0][0] = sr_n[TAP_TOP + 2];
        p[0][1] = sr_n[TAP_TOP + 1];
        p[0][2] = sr_n[TAP_TOP];
        p[1][0] = sr_n[TAP_MID + 2];
        p[1][1] = sr_n[TAP_MID + 1];
        p[1][2] = sr_n[TAP_MID];
        p[2][0] = sr_n[2];
        p[2][1] = sr_n[1];
        p[2][2] = sr_n[0];
`ifdef EDGE_WIN_BORDER_REPLICATE_EN
        // Columns first, then rows, so corners pick up the corner pixel
        for (int r = 0; r < 3; r++) begin
            if (cen_col_q == '0) p[r][0] = p[r][1];
            if (cen_last_col_c)  p[r][2] = p[r][1];
        end
        for (int c = 0; c < 3; c++) begin
            if (cen_row_q == '0) p[0][c] = p[1][c];
            if (cen_last_row_c)  p[2][c] = p[1][c];
        end
`else
        for (int r = 0; r < 3; r++) begin
            if (cen_col_q == '0) p[r][0] = 1'b0;
            if (cen_last_col_c)  p[r][2] = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            if (cen_row_q == '0) p[0][c] = 1'b0;
            if (cen_last_row_c)  p[2][c] = 1'b0;
        end
`endif
        win_c = {p[1][1], p[1][0], p[2][0], p[2][1], p[2][2],
                 p[1][2], p[0][2], p[0][1], p[0][0]};
    end

    // FSM next state
    always_comb begin
        state_n = state_q;
        case (state_q)
            FILL:    if (in_fire_c && fill_cnt_q == FILL_W'(IMG_W)) state_n = RUN;
            RUN:     if (in_fire_c && in_last_pix_c)                 state_n = FLUSH;
            FLUSH:   if (flush_fire_c && cen_last_c)                 state_n = FILL;
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            ready_en_q <= 1'b1;
        end
    end

    // Line buffers plus window taps as one shift chain; input and fill counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q       <= '0;
            in_col_q   <= '0;
            in_row_q   <= '0;
            fill_cnt_q <= '0;
        end else begin
            if (shift_en_c) sr_q <= sr_n[SR_LEN-1:0];
            if (in_fire_c) begin
                if (in_last_col_c) begin
                    in_col_q <= '0;
                    in_row_q <= in_last_row_c ? '0 : in_row_q + ROW_W'(1);
                end else begin
                    in_col_q <= in_col_q + COL_W'(1);
                end
            end
            if (state_q != FILL)  fill_cnt_q <= '0;
            else if (in_fire_c)   fill_cnt_q <= fill_cnt_q + FILL_W'(1);
        end
    end

    // Output register and centre position of the next window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_window <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            cen_col_q  <= '0;
            cen_row_q  <= '0;
        end else if (produce_c) begin
            out_window <= win_c;
            out_valid  <= 1'b1;
            out_last   <= cen_last_c;
            if (cen_last_col_c) begin
                cen_col_q <= '0;
                cen_row_q <= cen_last_row_c ? '0 : cen_row_q + ROW_W'(1);
            end else begin
                cen_col_q <= cen_col_q + COL_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edge_window_gen.sv
// Directed and randomised checks of edge_window_gen on 4x4 frames against a coordinate-based model.
module tb_edge_window_gen;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_pix = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] out_window;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;

    int n_cmp = 0;
    int n_err = 0;

    bit         stim_q[$];
    logic [8:0] got_q[$];
    logic       last_q[$];
    logic [8:0] res_a[NPIX];
    logic [8:0] res_b[NPIX];

    typedef struct {
        string      nm;
        int         frame;
        int         idx;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[12];

    edge_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(in_valid), .in_ready(in_ready),
        .out_window(out_window), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit px(input int base, input int r, input int c);
`ifdef EDGE_WIN_BORDER_REPLICATE_EN
        int rr = (r < 0) ? 0 : ((r >= H) ? H - 1 : r);
        int cc = (c < 0) ? 0 : ((c >= W) ? W - 1 : c);
        return stim_q[base + rr * W + cc];
`else
        if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
        return stim_q[base + r * W + c];
`endif
    endfunction

    function automatic logic [8:0] ref_win(input int base, input int r, input int c);
        logic [8:0] w;
        w[0] = px(base, r - 1, c - 1);
        w[1] = px(base, r - 1, c);
        w[2] = px(base, r - 1, c + 1);
        w[3] = px(base, r,     c + 1);
        w[4] = px(base, r + 1, c + 1);
        w[5] = px(base, r + 1, c);
        w[6] = px(base, r + 1, c - 1);
        w[7] = px(base, r,     c - 1);
        w[8] = px(base, r,     c);
        return w;
    endfunction

    // Streams stim_q and collects n_win output windows; optional 3-cycle-style stall at a window index
    task automatic run(input int n_win, input int vpct, input int rpct,
                       input int stall_at, input int stall_len, output int gap);
        int         acc = 0;
        int         cyc = 0;
        int         stalled = 0;
        bit         stall_now;
        logic [8:0] held = '0;
        gap = 0;
        got_q.delete();
        last_q.delete();
        while (got_q.size() < n_win) begin
            if (cyc >= 20000) begin
                chk("run_timeout", 32'(got_q.size()), 32'(n_win));
                break;
            end
            @(posedge clk);
            #1;
            in_valid = (acc < stim_q.size()) && ($urandom_range(99) < vpct);
            in_pix   = (acc < stim_q.size()) ? stim_q[acc] : 1'b0;
            stall_now = (stall_at >= 0) && (got_q.size() == stall_at) && out_valid && (stalled < stall_len);
            if (stall_now) begin
                out_ready = 1'b0;
                if (stalled == 0) held = out_window;
                stalled++;
            end else begin
                out_ready = ($urandom_range(99) < rpct);
            end
            @(negedge clk);
            if (stall_now) begin
                chk("stall_in_ready", 32'(in_ready), 32'(0));
                if (stalled > 1) chk("stall_hold", 32'(out_window), 32'(held));
            end
            if (acc == NPIX && !in_ready) gap++;
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_window);
                last_q.push_back(out_last);
            end
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_frames(input string nm, input int first_fr, input int nfr);
        int n = (got_q.size() < nfr * NPIX) ? got_q.size() : nfr * NPIX;
        int nlast = 0;
        chk({nm, "_count"}, 32'(got_q.size()), 32'(nfr * NPIX));
        for (int i = 0; i < n; i++) begin
            int f = i / NPIX;
            int k = i % NPIX;
            chk({nm, "_win"}, 32'(got_q[i]), 32'(ref_win((first_fr + f) * NPIX, k / W, k % W)));
            chk({nm, "_last"}, 32'(last_q[i]), 32'(k == NPIX - 1));
            if (last_q[i]) nlast++;
        end
        chk({nm, "_last_count"}, 32'(nlast), 32'(nfr));
    endtask

    initial begin
        int gap;

`ifdef EDGE_WIN_BORDER_REPLICATE_EN
        tbl[0] = '{"ones_w00", 0, 0,  9'h1FF};
        tbl[1] = '{"ones_w11", 0, 5,  9'h1FF};
        tbl[2] = '{"ones_w33", 0, 15, 9'h1FF};
        tbl[3] = '{"ones_w01", 0, 1,  9'h1FF};
        tbl[4] = '{"ones_w30", 0, 12, 9'h1FF};
`else
        tbl[0] = '{"ones_w00", 0, 0,  9'h138};
        tbl[1] = '{"ones_w11", 0, 5,  9'h1FF};
        tbl[2] = '{"ones_w33", 0, 15, 9'h183};
        tbl[3] = '{"ones_w01", 0, 1,  9'h1F8};
        tbl[4] = '{"ones_w30", 0, 12, 9'h10E};
`endif
        tbl[5]  = '{"dot_w00", 1, 0,  9'h010};
        tbl[6]  = '{"dot_w11", 1, 5,  9'h100};
        tbl[7]  = '{"dot_w22", 1, 10, 9'h001};
        tbl[8]  = '{"dot_w01", 1, 1,  9'h020};
        tbl[9]  = '{"dot_w10", 1, 4,  9'h008};
        tbl[10] = '{"dot_w02", 1, 2,  9'h040};
        tbl[11] = '{"dot_w33", 1, 15, 9'h000};

        // Reset values, then in_ready after release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_last", 32'(out_last), 32'(0));
        chk("rst_out_window", 32'(out_window), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));

        // Mid-stream reset: asynchronous, between clock edges
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_pix   = 1'b1;
            @(posedge clk);
            #1;
        end
        #2;
        chk("pre_rst_out_valid", 32'(out_valid), 32'(1));
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'(0));
        chk("async_rst_out_last", 32'(out_last), 32'(0));
        chk("async_rst_in_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // All-ones frame
        stim_q.delete();
        for (int i = 0; i < NPIX; i++) stim_q.push_back(1'b1);
        run(NPIX, 100, 100, -1, 0, gap);
        check_frames("ones", 0, 1);
        for (int i = 0; i < NPIX; i++) res_a[i] = (i < got_q.size()) ? got_q[i] : 'x;

        // Single set pixel at (1,1)
        stim_q.delete();
        for (int i = 0; i < NPIX; i++) stim_q.push_back(i == 5);
        run(NPIX, 100, 100, -1, 0, gap);
        check_frames("dot", 0, 1);
        for (int i = 0; i < NPIX; i++) res_b[i] = (i < got_q.size()) ? got_q[i] : 'x;

        for (int i = 0; i < 12; i++)
            chk(tbl[i].nm, 32'((tbl[i].frame == 0) ? res_a[tbl[i].idx] : res_b[tbl[i].idx]), 32'(tbl[i].exp));

        // Backpressure: 3-cycle stall while window 6 is presented
        run(NPIX, 100, 100, 6, 3, gap);
        check_frames("stall", 0, 1);

        // Back-to-back frames: ones then dot with in_valid held high
        stim_q.delete();
        for (int i = 0; i < NPIX; i++) stim_q.push_back(1'b1);
        for (int i = 0; i < NPIX; i++) stim_q.push_back(i == 5);
        run(2 * NPIX, 100, 100, -1, 0, gap);
        chk("b2b_flush_gap", 32'(gap), 32'(W + 1));
        check_frames("b2b", 0, 2);

        // Random pixels with random in_valid/out_ready over 20 frames
        stim_q.delete();
        for (int i = 0; i < 20 * NPIX; i++) stim_q.push_back(bit'($urandom_range(1)));
        run(20 * NPIX, 50, 50, -1, 0, gap);
        check_frames("rand", 0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
